// File: rtl/cnn_stim_driver.sv
// Stimulus and scoring engine for a simpleCNN instance: streams preloaded images
// row by row, waits for each classification and tallies correct and timed-out results.
module cnn_stim_driver #(
   parameter int NUM_IMAGES = 100,
   parameter int ROWS       = 28,
   parameter int IMG_W      = 200,
   parameter int ADDR_W     = 12,
   parameter int LBL_AW     = 7,
   parameter int CNT_W      = 8,
   parameter int TIMEOUT    = 4096
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              GO,
   output logic              MEM_RD,
   output logic [ADDR_W-1:0] MEM_ADDR,
   input  logic [IMG_W-1:0]  MEM_DATA,
   output logic [LBL_AW-1:0] LBL_ADDR,
   input  logic [3:0]        LBL_DATA,
   output logic              START,
   output logic              X,
   output logic              Y,
   output logic [IMG_W-1:0]  IMGIN,
   input  logic              DONE,
   input  logic [3:0]        OUT,
   output logic              BUSY,
   output logic              FINISH,
   output logic [CNT_W-1:0]  CORRECT,
   output logic [CNT_W-1:0]  TIMEOUTS,
   output logic              MISMATCH
);
   localparam int ROW_W  = $clog2(ROWS + 1);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, STRT, FETCH, PUSH, WAITD, CHECK, FIN} state_t;

   state_t             state_reg, state_next;
   logic [LBL_AW-1:0]  img_reg, img_next;
   logic [ROW_W-1:0]   row_reg, row_next;
   logic [ADDR_W-1:0]  base_reg, base_next;
   logic [WAIT_W-1:0]  wait_reg, wait_next;
   logic [LBL_AW-1:0]  lbl_addr_reg, lbl_addr_next;
   logic [IMG_W-1:0]   imgin_reg, imgin_next;
   logic [3:0]         out_reg, out_next;
   logic [CNT_W-1:0]   correct_reg, correct_next;
   logic [CNT_W-1:0]   timeouts_reg, timeouts_next;
   logic               advance;
   logic               last_img;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= IDLE;
         img_reg      <= '0;
         row_reg      <= '0;
         base_reg     <= '0;
         wait_reg     <= '0;
         lbl_addr_reg <= '0;
         imgin_reg    <= '0;
         out_reg      <= '0;
         correct_reg  <= '0;
         timeouts_reg <= '0;
      end else begin
         state_reg    <= state_next;
         img_reg      <= img_next;
         row_reg      <= row_next;
         base_reg     <= base_next;
         wait_reg     <= wait_next;
         lbl_addr_reg <= lbl_addr_next;
         imgin_reg    <= imgin_next;
         out_reg      <= out_next;
         correct_reg  <= correct_next;
         timeouts_reg <= timeouts_next;
      end
   end

   assign last_img = (img_reg == LBL_AW'(NUM_IMAGES - 1));

   always_comb begin
      state_next    = state_reg;
      img_next      = img_reg;
      row_next      = row_reg;
      base_next     = base_reg;
      wait_next     = wait_reg;
      lbl_addr_next = lbl_addr_reg;
      imgin_next    = imgin_reg;
      out_next      = out_reg;
      correct_next  = correct_reg;
      timeouts_next = timeouts_reg;
      START         = 1'b0;
      MEM_RD        = 1'b0;
      X             = 1'b0;
      Y             = 1'b0;
      MISMATCH      = 1'b0;
      advance       = 1'b0;
      case (state_reg)
         IDLE, FIN: begin
            if (GO) begin
               correct_next  = '0;
               timeouts_next = '0;
               img_next      = '0;
               base_next     = '0;
               state_next    = STRT;
            end
         end
         STRT: begin
            START         = 1'b1;
            row_next      = '0;
            lbl_addr_next = img_reg;
            state_next    = FETCH;
         end
         FETCH: begin
            MEM_RD     = 1'b1;
            state_next = PUSH;
         end
         PUSH: begin
            X          = 1'b1;
            Y          = (row_reg == ROW_W'(ROWS - 1));
            imgin_next = MEM_DATA;
            if (row_reg < ROW_W'(ROWS - 1)) begin
               row_next   = row_reg + ROW_W'(1);
               state_next = FETCH;
            end else begin
               wait_next  = '0;
               state_next = WAITD;
            end
         end
         WAITD: begin
            wait_next = wait_reg + WAIT_W'(1);
            // DONE takes priority over expiry on the final wait cycle
            if (DONE) begin
               out_next   = OUT;
               state_next = CHECK;
            end else if (wait_reg == WAIT_W'(TIMEOUT - 1)) begin
               if (timeouts_reg != {CNT_W{1'b1}})
                  timeouts_next = timeouts_reg + CNT_W'(1);
               advance = 1'b1;
            end
         end
         CHECK: begin
            if (out_reg == LBL_DATA) begin
               if (correct_reg != {CNT_W{1'b1}})
                  correct_next = correct_reg + CNT_W'(1);
            end else begin
               MISMATCH = 1'b1;
            end
            advance = 1'b1;
         end
         default: state_next = IDLE;
      endcase
      if (advance) begin
         if (last_img) begin
            state_next = FIN;
         end else begin
            img_next   = img_reg + LBL_AW'(1);
            base_next  = base_reg + ADDR_W'(ROWS);
            state_next = STRT;
         end
      end
   end

   // IMGIN shows the memory word directly during PUSH and holds it afterwards
   assign IMGIN    = X ? MEM_DATA : imgin_reg;
   assign MEM_ADDR = base_reg + ADDR_W'(row_reg);
   assign LBL_ADDR = lbl_addr_reg;
   assign BUSY     = (state_reg != IDLE) && (state_reg != FIN);
   assign FINISH   = (state_reg == FIN);
   assign CORRECT  = correct_reg;
   assign TIMEOUTS = timeouts_reg;
endmodule

// File: tb/tb_cnn_stim_driver.sv
// Self-checking bench: a small CNN/memory model around cnn_stim_driver, driven by a
// table of run scenarios plus hand sequences for reset, busy-GO and saturation.
module tb_cnn_stim_driver;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, go, go2, mclr, inj_en;
   logic         mem_rd, start, x, y, busy, finish, mismatch, done;
   logic [11:0]  mem_addr;
   logic [199:0] mem_data, imgin;
   logic [6:0]   lbl_addr;
   logic [3:0]   lbl_data, out;
   logic [7:0]   correct, timeouts;

   logic         mem_rd2, start2, x2, y2, busy2, finish2, mismatch2, done2;
   logic [11:0]  mem_addr2;
   logic [199:0] mem_data2, imgin2;
   logic [6:0]   lbl_addr2;
   logic [3:0]   lbl_data2, out2;
   logic [1:0]   correct2, timeouts2;

   cnn_stim_driver #(.NUM_IMAGES(3), .ROWS(2), .IMG_W(200), .ADDR_W(12), .LBL_AW(7),
                     .CNT_W(8), .TIMEOUT(16)) dut (
      .CLK(clk), .RST(rst), .GO(go), .MEM_RD(mem_rd), .MEM_ADDR(mem_addr),
      .MEM_DATA(mem_data), .LBL_ADDR(lbl_addr), .LBL_DATA(lbl_data), .START(start),
      .X(x), .Y(y), .IMGIN(imgin), .DONE(done), .OUT(out), .BUSY(busy),
      .FINISH(finish), .CORRECT(correct), .TIMEOUTS(timeouts), .MISMATCH(mismatch));

   cnn_stim_driver #(.NUM_IMAGES(5), .ROWS(2), .IMG_W(200), .ADDR_W(12), .LBL_AW(7),
                     .CNT_W(2), .TIMEOUT(16)) dut2 (
      .CLK(clk), .RST(rst), .GO(go2), .MEM_RD(mem_rd2), .MEM_ADDR(mem_addr2),
      .MEM_DATA(mem_data2), .LBL_ADDR(lbl_addr2), .LBL_DATA(lbl_data2), .START(start2),
      .X(x2), .Y(y2), .IMGIN(imgin2), .DONE(done2), .OUT(out2), .BUSY(busy2),
      .FINISH(finish2), .CORRECT(correct2), .TIMEOUTS(timeouts2), .MISMATCH(mismatch2));

   // Memories: every image row holds its own address; labels come from a table.
   logic [3:0] lbl_tab [3];
   logic [3:0] pred_tab [3];
   int         dly_tab [3];
   always @(posedge clk) begin
      if (mem_rd) mem_data <= 200'(mem_addr);
      lbl_data <= (lbl_addr < 7'd3) ? lbl_tab[lbl_addr[1:0]] : 4'd0;
   end

   // CNN model: DONE arrives dly+1 cycles after Y (dly=0 means never)
   int         ycnt, cd;
   logic       done_m, done_inj;
   logic [3:0] out_m;
   always @(posedge clk) begin
      done_m <= 1'b0;
      if (rst || mclr) begin
         ycnt <= 0;
         cd   <= 0;
      end else if (x && y) begin
         cd   <= dly_tab[ycnt % 3];
         ycnt <= ycnt + 1;
      end else if (cd > 1) begin
         cd <= cd - 1;
      end else if (cd == 1) begin
         done_m <= 1'b1;
         out_m  <= pred_tab[(ycnt - 1) % 3];
         cd     <= 0;
      end
   end
   always @(negedge clk) done_inj = inj_en && (mem_rd || x);
   assign done = done_m | done_inj;
   assign out  = done_inj ? 4'hF : out_m;

   // Second instance: always answers correctly one cycle after Y
   int y2cnt;
   always @(posedge clk) begin
      if (mem_rd2) mem_data2 <= 200'(mem_addr2);
      lbl_data2 <= lbl_addr2[3:0];
      done2     <= 1'b0;
      if (rst) begin
         y2cnt <= 0;
      end else if (x2 && y2) begin
         done2 <= 1'b1;
         out2  <= y2cnt[3:0];
         y2cnt <= y2cnt + 1;
      end
   end

   // Stream monitor
   int         xk, mon_bad, starts, mm_cnt;
   logic [2:0] mm_mask;
   always @(negedge clk) begin
      if (mclr) begin
         xk = 0; mon_bad = 0; starts = 0; mm_cnt = 0; mm_mask = 3'b0;
      end else begin
         if (start) starts++;
         if (x) begin
            if (imgin !== 200'(xk) || y !== (xk % 2 == 1)) mon_bad++;
            xk++;
         end
         if (mismatch) begin
            mm_cnt++;
            if (ycnt >= 1 && ycnt <= 3) mm_mask[ycnt-1] = 1'b1;
         end
      end
   end

   int checks = 0, errors = 0;
   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   typedef struct packed {
      logic [2:0][3:0] lbl;
      logic [2:0][3:0] pred;
      logic [2:0][4:0] dly;
      logic            inj;
      logic            go_busy;
      logic [7:0]      exp_c;
      logic [7:0]      exp_t;
      logic [2:0]      exp_mm;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] l0, l1, l2, p0, p1, p2,
                               input logic [4:0] d0, d1, d2, input logic inj, gb,
                               input logic [7:0] c, t, input logic [2:0] mm);
      vec_t v;
      v.lbl = {l2, l1, l0}; v.pred = {p2, p1, p0}; v.dly = {d2, d1, d0};
      v.inj = inj; v.go_busy = gb; v.exp_c = c; v.exp_t = t; v.exp_mm = mm;
      return v;
   endfunction

   task automatic pulse_go_clr();
      @(posedge clk); #1; go = 1'b1; mclr = 1'b1;
      @(posedge clk); #1; go = 1'b0; mclr = 1'b0;
   endtask

   task automatic run(input int idx, input vec_t v);
      int n;
      for (int i = 0; i < 3; i++) begin
         lbl_tab[i] = v.lbl[i]; pred_tab[i] = v.pred[i]; dly_tab[i] = int'(v.dly[i]);
      end
      inj_en = v.inj;
      pulse_go_clr();
      chk("start_after_go", start, 1);
      chk("busy_after_go", busy, 1);
      chk("cleared_on_go", {finish, correct, timeouts}, 0);
      if (v.go_busy) begin
         repeat (5) @(posedge clk);
         #1 go = 1'b1;
         @(posedge clk); #1 go = 1'b0;
      end
      n = 0;
      while (!finish && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      chk("finish_reached", finish, 1);
      chk("correct", correct, v.exp_c);
      chk("timeouts", timeouts, v.exp_t);
      chk("mismatch_images", mm_mask, v.exp_mm);
      chk("mismatch_pulses", mm_cnt, $countones(v.exp_mm));
      chk("busy_at_fin", busy, 0);
      chk("start_count", starts, 3);
      chk("row_count", xk, 6);
      chk("stream_rows", mon_bad, 0);
      inj_en = 1'b0;
      $display("run %0d: correct=%0d timeouts=%0d mm_mask=%b starts=%0d rows=%0d cycles=%0d",
               idx, correct, timeouts, mm_mask, starts, xk, n);
   endtask

   vec_t vecs [7];
   int   act, n2;

   initial begin
      vecs[0] = mk(2, 7, 9, 2, 7, 9,  9, 9, 9, 0, 0, 3, 0, 3'b000); // all correct
      vecs[1] = mk(2, 7, 9, 2, 5, 9,  9, 9, 9, 0, 0, 2, 0, 3'b010); // image 1 wrong
      vecs[2] = mk(1, 2, 3, 1, 2, 3,  9, 0, 9, 0, 0, 2, 1, 3'b000); // image 1 never done
      vecs[3] = mk(1, 2, 3, 1, 2, 3, 15,15,15, 0, 0, 3, 0, 3'b000); // DONE on last wait cycle
      vecs[4] = mk(4, 5, 6, 4, 5, 6, 16, 9, 9, 0, 0, 2, 1, 3'b000); // DONE one cycle late
      vecs[5] = mk(2, 7, 9, 2, 7, 9,  9, 9, 9, 1, 0, 3, 0, 3'b000); // DONE during stream
      vecs[6] = mk(0, 0, 0, 1, 2, 3,  3, 3, 3, 0, 1, 0, 0, 3'b111); // GO while busy
      rst = 1'b1; go = 1'b0; go2 = 1'b0; mclr = 1'b0; inj_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         lbl_tab[i] = 4'd0; pred_tab[i] = 4'd0; dly_tab[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {start, mem_rd, mem_addr, lbl_addr, x, y, imgin, busy, finish,
                            correct, timeouts, mismatch}, 0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) run(i, vecs[i]);

      // Reset in the middle of image 1's first row push
      for (int i = 0; i < 3; i++) begin
         lbl_tab[i] = vecs[0].lbl[i]; pred_tab[i] = vecs[0].pred[i]; dly_tab[i] = 9;
      end
      pulse_go_clr();
      n2 = 0;
      while (!(x && xk == 2) && n2 < 200) begin
         @(posedge clk); #1; n2++;
      end
      chk("reached_img1_push", {x, imgin}, {1'b1, 200'd2});
      rst = 1'b1;
      @(posedge clk); #1;
      chk("outputs_after_rst", {start, mem_rd, mem_addr, lbl_addr, x, y, imgin, busy,
                                finish, correct, timeouts, mismatch}, 0);
      rst = 1'b0;
      act = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (busy || start || mem_rd || x) act++;
      end
      chk("idle_after_rst", act, 0);
      $display("rst mid-push: outputs cleared, idle cycles checked");
      run(7, vecs[0]);

      // Saturating counter on the narrow instance
      @(posedge clk); #1 go2 = 1'b1;
      @(posedge clk); #1 go2 = 1'b0;
      n2 = 0;
      while (!finish2 && n2 < 1000) begin
         @(posedge clk); #1; n2++;
      end
      chk("sat_finish", finish2, 1);
      chk("sat_correct", correct2, 2'd3);
      chk("sat_timeouts", timeouts2, 2'd0);
      $display("saturation run: correct=%0d timeouts=%0d cycles=%0d", correct2, timeouts2, n2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
